// File: rtl/hdlc_rx_reader.sv
// hdlc_rx_reader: host-side reader for the Hdlc receiver.
//   When Rx_Ready is seen (and Enable is high in IDLE), reads Rx_SC and Rx_Len
//   through the Hdlc register port. It then drains Rx_Buff one byte at a time
//   onto a valid/ready byte stream with an end-of-frame marker. Bad frames are
//   dropped by writing 8'h02 to Rx_SC. Every non-clean frame raises frame_err
//   for one cycle, and err_code carries the reason.
// Ports:
//   Clk, Rst (async, active-low), Enable, Rx_Ready
//   Address/ReadEnable/WriteEnable/DataIn -> Hdlc register port; DataOut <- Hdlc
//   m_data/m_valid/m_last/m_ready         byte stream out
//   frame_err (pulse), err_code {badlen, overflow, frame error/abort}
// Optional: define HDLC_RX_READER_STATS_EN to add saturating frames_ok/frames_bad counters.
// MAX_LEN must be <= 127 because the byte counter is 7 bits wide.
module hdlc_rx_reader #(
  parameter int MAX_LEN = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Enable,
  input  logic       Rx_Ready,
  output logic [2:0] Address,
  output logic       ReadEnable,
  output logic       WriteEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_err,
  output logic [2:0] err_code
`ifdef HDLC_RX_READER_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
`endif
);

  typedef enum logic [3:0] {
    IDLE, RD_SC, CHK_SC, RD_LEN, CHK_LEN, RD_BUF, CAP, HOLD, DROP
  } state_t;

  localparam logic [8:0] LP_MAX = MAX_LEN[8:0];

  state_t     r_state, w_nxt;
  logic [6:0] r_cnt, w_cnt;
  logic       r_ovf, w_ovf;
  logic [2:0] r_addr, w_addr;
  logic       r_re, w_re, r_we, w_we;
  logic [7:0] r_din, w_din;
  logic [7:0] r_mdata, w_mdata;
  logic       r_mvalid, w_mvalid, r_mlast, w_mlast;
  logic       r_ferr, w_ferr;
  logic [2:0] r_ecode, w_ecode;

  always_comb begin
    w_nxt    = r_state;
    w_cnt    = r_cnt;
    w_ovf    = r_ovf;
    w_mdata  = r_mdata;
    w_mvalid = r_mvalid;
    w_mlast  = r_mlast;
    w_ferr   = 1'b0;
    w_ecode  = r_ecode;
    case (r_state)
      IDLE: if (Rx_Ready && Enable) begin
        w_nxt = RD_SC;
        w_ovf = 1'b0;
      end
      RD_SC:  w_nxt = CHK_SC;
      CHK_SC: begin
        // FrameError (bit2) or AbortSignal (bit3) kills the frame outright.
        if (DataOut[2] || DataOut[3]) begin
          w_nxt   = DROP;
          w_ferr  = 1'b1;
          w_ecode = 3'b001;
        end else begin
          w_ovf = DataOut[4];
          w_nxt = RD_LEN;
        end
      end
      RD_LEN:  w_nxt = CHK_LEN;
      CHK_LEN: begin
        w_cnt = DataOut[6:0];
        // Compare the full byte so lengths >= 128 cannot alias into range.
        if (DataOut[6:0] == 7'd0 || {1'b0, DataOut} > LP_MAX) begin
          w_nxt   = DROP;
          w_ferr  = 1'b1;
          w_ecode = {1'b1, r_ovf, 1'b0};
        end else begin
          w_nxt = RD_BUF;
        end
      end
      RD_BUF: w_nxt = CAP;
      CAP: begin
        w_mdata  = DataOut;
        w_mvalid = 1'b1;
        w_mlast  = (r_cnt == 7'd1);
        w_nxt    = HOLD;
      end
      HOLD: if (r_mvalid && m_ready) begin
        w_mvalid = 1'b0;
        w_cnt    = r_cnt - 7'd1;
        if (r_cnt == 7'd1) begin
          w_nxt = IDLE;
          if (r_ovf) begin
            w_ferr  = 1'b1;
            w_ecode = 3'b010;
          end
        end else begin
          w_nxt = RD_BUF;
        end
      end
      DROP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    w_re   = 1'b0;
    w_we   = 1'b0;
    w_addr = 3'd0;
    w_din  = 8'h00;
    case (w_nxt)
      RD_SC:  begin w_re = 1'b1; w_addr = 3'd2; end
      RD_LEN: begin w_re = 1'b1; w_addr = 3'd4; end
      RD_BUF: begin w_re = 1'b1; w_addr = 3'd3; end
      DROP:   begin w_we = 1'b1; w_addr = 3'd2; w_din = 8'h02; end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= IDLE;
      r_cnt    <= 7'd0;
      r_ovf    <= 1'b0;
      r_addr   <= 3'd0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_din    <= 8'h00;
      r_mdata  <= 8'h00;
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ecode  <= 3'd0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt;
      r_ovf    <= w_ovf;
      r_addr   <= w_addr;
      r_re     <= w_re;
      r_we     <= w_we;
      r_din    <= w_din;
      r_mdata  <= w_mdata;
      r_mvalid <= w_mvalid;
      r_mlast  <= w_mlast;
      r_ferr   <= w_ferr;
      r_ecode  <= w_ecode;
    end
  end

  assign Address     = r_addr;
  assign ReadEnable  = r_re;
  assign WriteEnable = r_we;
  assign DataIn      = r_din;
  assign m_data      = r_mdata;
  assign m_valid     = r_mvalid;
  assign m_last      = r_mlast;
  assign frame_err   = r_ferr;
  assign err_code    = r_ecode;

`ifdef HDLC_RX_READER_STATS_EN
  logic r_ok_hs;
  assign r_ok_hs = (r_state == HOLD) && r_mvalid && m_ready && (r_cnt == 7'd1) && !r_ovf;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      frames_ok  <= 16'd0;
      frames_bad <= 16'd0;
    end else begin
      if (r_ok_hs && frames_ok != 16'hFFFF)    frames_ok  <= frames_ok + 16'd1;
      if (r_ferr && frames_bad != 16'hFFFF)    frames_bad <= frames_bad + 16'd1;
    end
  end
`endif

endmodule
